// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with immediate-format decode, stall/flush and post-reset imem warm-up
module if_id_stage #(
  parameter logic [31:0] PC_RESET     = 32'h0000_2000,
  parameter int          IMEM_LATENCY = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] imem_dout,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_valid,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        valid,
  output logic [2:0]  ImmSel,
  output logic        illegal
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [2:0]  LAT = 3'(IMEM_LATENCY);
  typedef enum logic {WARM, RUN} state_t;
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] inst_q, inst_d, pc_q, pc_d;
  logic        valid_q, valid_d, ill_q, ill_d, dec_ill;
  logic [2:0]  sel_q, sel_d, dec_sel;
  logic [6:0]  op;
  logic [2:0]  f3;
  assign op = imem_dout[6:0];
  assign f3 = imem_dout[14:12];
  always_comb begin
    dec_sel = 3'b000;
    dec_ill = 1'b0;
    case (op)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0110011: dec_sel = 3'b000;
      7'b1110011: dec_sel = f3[2] && f3 != 3'b100 ? 3'b101 : 3'b000;
      7'b0100011: dec_sel = 3'b001;
      7'b1100011: dec_sel = 3'b010;
      7'b0110111, 7'b0010111: dec_sel = 3'b011;
      7'b1101111: dec_sel = 3'b100;
      default: dec_ill = 1'b1;
    endcase
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    ill_d   = ill_q;
    if (state_q == WARM) begin
      cnt_d   = cnt_q + 3'd1;
      state_d = cnt_d == LAT ? RUN : WARM;
      inst_d  = NOP;
      valid_d = 1'b0;
      sel_d   = 3'b000;
      ill_d   = 1'b0;
    end else if (flush) begin
      inst_d  = NOP;
      pc_d    = fetch_pc;
      valid_d = 1'b0;
      sel_d   = 3'b000;
      ill_d   = 1'b0;
    end else if (!stall) begin
      inst_d  = fetch_valid ? imem_dout : NOP;
      pc_d    = fetch_pc;
      valid_d = fetch_valid;
      sel_d   = fetch_valid && !dec_ill ? dec_sel : 3'b000;
      ill_d   = fetch_valid && dec_ill;
    end
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= WARM;
      cnt_q   <= 3'd0;
      inst_q  <= NOP;
      pc_q    <= PC_RESET;
      valid_q <= 1'b0;
      sel_q   <= 3'b000;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      ill_q   <= ill_d;
    end
  end
  assign inst    = inst_q;
  assign pc      = pc_q;
  assign valid   = valid_q;
  assign ImmSel  = sel_q;
  assign illegal = ill_q;
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: table-driven directed checks of the IF/ID register and ImmSel decode
module tb_if_id_stage;
  logic        clk = 1'b0;
  logic        rst, fv, st, fl;
  logic [31:0] dout, fpc;
  logic [31:0] inst, pc;
  logic        valid, illegal;
  logic [2:0]  ImmSel;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  if_id_stage #(.PC_RESET(32'h0000_2000), .IMEM_LATENCY(1)) dut (
    .Clock(clk), .Reset(rst), .imem_dout(dout), .fetch_pc(fpc), .fetch_valid(fv),
    .stall(st), .flush(fl), .inst(inst), .pc(pc), .valid(valid), .ImmSel(ImmSel),
    .illegal(illegal)
  );
  typedef struct {
    logic        rst;
    logic [31:0] dout;
    logic [31:0] fpc;
    logic        fv, st, fl;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [2:0]  e_sel;
    logic        e_ill;
  } vec_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  vec_t v [$];
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask
  task automatic add(input logic r, input logic [31:0] d, input logic [31:0] p, input logic f, input logic s,
                     input logic fx, input logic [31:0] ei, input logic [31:0] ep, input logic ev,
                     input logic [2:0] es, input logic eil);
    vec_t t;
    t.rst = r; t.dout = d; t.fpc = p; t.fv = f; t.st = s; t.fl = fx;
    t.e_inst = ei; t.e_pc = ep; t.e_valid = ev; t.e_sel = es; t.e_ill = eil;
    v.push_back(t);
  endtask
  initial begin
    // reset 3 cycles with fetch_valid high, then one warm-up bubble
    add(1, 32'hFCE08793, 32'h2000, 1, 0, 0, NOP, 32'h2000, 0, 3'b000, 0);
    add(1, 32'hFCE08793, 32'h2000, 1, 0, 0, NOP, 32'h2000, 0, 3'b000, 0);
    add(1, 32'hFCE08793, 32'h2000, 1, 0, 0, NOP, 32'h2000, 0, 3'b000, 0);
    add(0, 32'hFCE08793, 32'h2000, 1, 0, 0, NOP, 32'h2000, 0, 3'b000, 0);
    // one of each immediate format
    add(0, 32'hFCE08793, 32'h2000, 1, 0, 0, 32'hFCE08793, 32'h2000, 1, 3'b000, 0);
    add(0, 32'h00E12423, 32'h2004, 1, 0, 0, 32'h00E12423, 32'h2004, 1, 3'b001, 0);
    add(0, 32'h00A98863, 32'h2008, 1, 0, 0, 32'h00A98863, 32'h2008, 1, 3'b010, 0);
    add(0, 32'h000052B7, 32'h200C, 1, 0, 0, 32'h000052B7, 32'h200C, 1, 3'b011, 0);
    add(0, 32'h014000EF, 32'h2010, 1, 0, 0, 32'h014000EF, 32'h2010, 1, 3'b100, 0);
    add(0, 32'h34015073, 32'h2014, 1, 0, 0, 32'h34015073, 32'h2014, 1, 3'b101, 0);
    // stall 3 cycles while imem moves on
    add(0, 32'h00A98863, 32'h2010, 1, 0, 0, 32'h00A98863, 32'h2010, 1, 3'b010, 0);
    add(0, 32'h014000EF, 32'h2014, 1, 1, 0, 32'h00A98863, 32'h2010, 1, 3'b010, 0);
    add(0, 32'h014000EF, 32'h2014, 1, 1, 0, 32'h00A98863, 32'h2010, 1, 3'b010, 0);
    add(0, 32'h014000EF, 32'h2014, 1, 1, 0, 32'h00A98863, 32'h2010, 1, 3'b010, 0);
    add(0, 32'h014000EF, 32'h2014, 1, 0, 0, 32'h014000EF, 32'h2014, 1, 3'b100, 0);
    // flush beats stall
    add(0, 32'h00E12423, 32'h2018, 1, 0, 0, 32'h00E12423, 32'h2018, 1, 3'b001, 0);
    add(0, 32'h000052B7, 32'h201C, 1, 1, 1, NOP, 32'h201C, 0, 3'b000, 0);
    // illegal opcode, then same word without fetch_valid
    add(0, 32'h0000007F, 32'h2020, 1, 0, 0, 32'h0000007F, 32'h2020, 1, 3'b000, 1);
    add(0, 32'h0000007F, 32'h2024, 0, 0, 0, NOP, 32'h2024, 0, 3'b000, 0);
    add(0, 32'h0000007F, 32'h2026, 1, 0, 0, 32'h0000007F, 32'h2026, 1, 3'b000, 1);
    add(0, 32'h34015073, 32'h2028, 1, 0, 1, NOP, 32'h2028, 0, 3'b000, 0);
    // remaining opcode classes
    add(0, 32'h00B50533, 32'h202C, 1, 0, 0, 32'h00B50533, 32'h202C, 1, 3'b000, 0);
    add(0, 32'h34011073, 32'h2030, 1, 0, 0, 32'h34011073, 32'h2030, 1, 3'b000, 0);
    add(0, 32'h000080E7, 32'h2034, 1, 0, 0, 32'h000080E7, 32'h2034, 1, 3'b000, 0);
    add(0, 32'h00012083, 32'h2038, 1, 0, 0, 32'h00012083, 32'h2038, 1, 3'b000, 0);
    add(0, 32'h00001097, 32'h203C, 1, 0, 0, 32'h00001097, 32'h203C, 1, 3'b011, 0);
    add(0, 32'h3401E073, 32'h2040, 1, 0, 0, 32'h3401E073, 32'h2040, 1, 3'b101, 0);
    add(0, 32'h3401C073, 32'h2044, 1, 0, 0, 32'h3401C073, 32'h2044, 1, 3'b000, 0);
    // reset mid-stream during stall, warm-up bubble repeats
    add(0, 32'h00E12423, 32'h2048, 1, 1, 0, 32'h3401C073, 32'h2044, 1, 3'b000, 0);
    add(1, 32'h00E12423, 32'h2048, 1, 1, 0, NOP, 32'h2000, 0, 3'b000, 0);
    add(0, 32'h00E12423, 32'h204C, 1, 0, 0, NOP, 32'h2000, 0, 3'b000, 0);
    add(0, 32'h00E12423, 32'h2050, 1, 0, 0, 32'h00E12423, 32'h2050, 1, 3'b001, 0);
    rst = 1; dout = 0; fpc = 0; fv = 0; st = 0; fl = 0;
    @(negedge clk);
    foreach (v[i]) begin
      rst = v[i].rst; dout = v[i].dout; fpc = v[i].fpc;
      fv = v[i].fv; st = v[i].st; fl = v[i].fl;
      @(posedge clk);
      #1;
      chk("inst", i, inst, v[i].e_inst);
      chk("pc", i, pc, v[i].e_pc);
      chk("valid", i, 32'(valid), 32'(v[i].e_valid));
      chk("ImmSel", i, 32'(ImmSel), 32'(v[i].e_sel));
      chk("illegal", i, 32'(illegal), 32'(v[i].e_ill));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
